// File: rtl/max7219_pkg.sv
// Shared types and constants for the MAX7219 configuration sequencer.
// Frame layout matches the 16-bit word shifted into each device: {4'h0, addr, value}.
package max7219_pkg;

  typedef logic [3:0] reg_addr_t;

  localparam reg_addr_t REG_NOOP         = 4'h0;
  localparam reg_addr_t REG_DIGIT0       = 4'h1;
  localparam reg_addr_t REG_DIGIT1       = 4'h2;
  localparam reg_addr_t REG_DIGIT2       = 4'h3;
  localparam reg_addr_t REG_DIGIT3       = 4'h4;
  localparam reg_addr_t REG_DIGIT4       = 4'h5;
  localparam reg_addr_t REG_DIGIT5       = 4'h6;
  localparam reg_addr_t REG_DIGIT6       = 4'h7;
  localparam reg_addr_t REG_DIGIT7       = 4'h8;
  localparam reg_addr_t REG_DECODE       = 4'h9;
  localparam reg_addr_t REG_INTENSITY    = 4'hA;
  localparam reg_addr_t REG_SCAN_LIMIT   = 4'hB;
  localparam reg_addr_t REG_SHUTDOWN     = 4'hC;
  localparam reg_addr_t REG_DISPLAY_TEST = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_START,
    ST_WAIT_DONE,
    ST_NEXT,
    ST_FINISH
  } state_e;

  // Which step list the sequencer is walking.
  typedef enum logic {
    LIST_INIT,
    LIST_UPD
  } list_e;

  typedef logic [2:0] step_idx_t;

  function automatic logic [15:0] pack_frame(input reg_addr_t addr, input logic [7:0] value);
    return {4'h0, addr, value};
  endfunction

endpackage

// File: rtl/max7219_cfg_rom.sv
// Step-list lookup: maps (list, step) to the register write for that step.
// Keeps the sequencing FSM ignorant of which registers it is writing.
module max7219_cfg_rom
  import max7219_pkg::*;
#(
  parameter logic [7:0] G_DECODE_MODE = 8'h00,
  parameter logic [7:0] G_INTENSITY   = 8'h08,
  parameter logic [7:0] G_SCAN_LIMIT  = 8'h07
) (
  input  list_e      i_list,
  input  step_idx_t  i_step,
  input  logic [3:0] i_intensity,
  output reg_addr_t  o_addr,
  output logic [7:0] o_value,
  output logic       o_last_step
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_addr      = REG_NOOP;
    o_value     = 8'h00;
    o_last_step = 1'b1;
    if (i_list == LIST_UPD) begin
      o_addr  = REG_INTENSITY;
      o_value = {4'h0, i_intensity};
    end else begin
      case (i_step)
        3'd0: begin
          o_addr      = REG_DISPLAY_TEST;
          o_value     = 8'h00;
          o_last_step = 1'b0;
        end
        3'd1: begin
          o_addr      = REG_DECODE;
          o_value     = G_DECODE_MODE;
          o_last_step = 1'b0;
        end
        3'd2: begin
          o_addr      = REG_INTENSITY;
          o_value     = {4'h0, G_INTENSITY[3:0]};
          o_last_step = 1'b0;
        end
        3'd3: begin
          o_addr      = REG_SCAN_LIMIT;
          o_value     = G_SCAN_LIMIT;
          o_last_step = 1'b0;
        end
        3'd4: begin
          o_addr      = REG_SHUTDOWN;
          o_value     = 8'h01;
          o_last_step = 1'b1;
        end
        default: begin
          o_addr      = REG_NOOP;
          o_value     = 8'h00;
          o_last_step = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/max7219_cfg_sequencer.sv
// Drives the max7219_if start/load/data handshake through the power-up list or a
// single intensity update, one frame per cascaded device, with a done watchdog.
module max7219_cfg_sequencer
  import max7219_pkg::*;
#(
  parameter int         G_NB_MATRIX    = 8,
  parameter logic [7:0] G_DECODE_MODE  = 8'h00,
  parameter logic [7:0] G_INTENSITY    = 8'h08,
  parameter logic [7:0] G_SCAN_LIMIT   = 8'h07,
  parameter int         G_DONE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_init,
  input  logic        i_upd_int,
  input  logic [3:0]  i_intensity,
  output logic        o_start,
  output logic        o_en_load,
  output logic [15:0] o_data,
  input  logic        i_if_done,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam int FW = (G_NB_MATRIX > 1) ? $clog2(G_NB_MATRIX) : 1;
  localparam int TW = (G_DONE_TIMEOUT > 1) ? $clog2(G_DONE_TIMEOUT) : 1;
  localparam logic [FW-1:0] FRAME_LAST   = FW'(G_NB_MATRIX - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(G_DONE_TIMEOUT - 1);

  state_e          state_q, state_d;
  list_e           list_q, list_d;
  step_idx_t       step_q, step_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            pend_q, pend_d;
  logic [3:0]      pend_int_q, pend_int_d;
  logic [3:0]      act_int_q, act_int_d;
  logic            last_q, last_d;
  logic            start_q, start_d;
  logic            en_load_q, en_load_d;
  logic [15:0]     data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  step_idx_t       rom_step;
  reg_addr_t       rom_addr;
  logic [7:0]      rom_value;
  logic            rom_last;
  logic            frame_wrap;

  assign frame_wrap = (frame_q == FRAME_LAST);

  // The ROM looks one step ahead when NEXT crosses a step boundary, so the new
  // frame is registered in the same cycle the counters move.
  always_comb begin
    rom_step = step_q;
    if (state_q == ST_SETUP) begin
      rom_step = '0;
    end else if (state_q == ST_NEXT && frame_wrap) begin
      rom_step = step_q + 3'd1;
    end
  end

  max7219_cfg_rom #(
    .G_DECODE_MODE (G_DECODE_MODE),
    .G_INTENSITY   (G_INTENSITY),
    .G_SCAN_LIMIT  (G_SCAN_LIMIT)
  ) u_rom (
    .i_list      (list_q),
    .i_step      (rom_step),
    .i_intensity (act_int_q),
    .o_addr      (rom_addr),
    .o_value     (rom_value),
    .o_last_step (rom_last)
  );

  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    step_d     = step_q;
    frame_d    = frame_q;
    tmo_d      = tmo_q;
    pend_d     = pend_q;
    pend_int_d = pend_int_q;
    act_int_d  = act_int_q;
    last_d     = last_q;
    start_d    = 1'b0;
    en_load_d  = en_load_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    // Updates arriving mid-sequence collapse into one pending request, newest value wins.
    if (i_upd_int && state_q != ST_IDLE) begin
      pend_d     = 1'b1;
      pend_int_d = i_intensity;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_init) begin
          list_d  = LIST_INIT;
          state_d = ST_SETUP;
          busy_d  = 1'b1;
          if (i_upd_int) begin
            pend_d     = 1'b1;
            pend_int_d = i_intensity;
          end
        end else if (pend_q || i_upd_int) begin
          list_d    = LIST_UPD;
          act_int_d = i_upd_int ? i_intensity : pend_int_q;
          pend_d    = 1'b0;
          state_d   = ST_SETUP;
          busy_d    = 1'b1;
        end
      end
      ST_SETUP: begin
        step_d    = '0;
        frame_d   = '0;
        data_d    = pack_frame(rom_addr, rom_value);
        en_load_d = (FRAME_LAST == '0);
        last_d    = rom_last;
        state_d   = ST_START;
      end
      ST_START: begin
        start_d = 1'b1;
        tmo_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_if_done) begin
          state_d = ST_NEXT;
        end else if (tmo_q == TIMEOUT_LAST) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_NEXT: begin
        if (frame_wrap && last_q) begin
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          if (frame_wrap) begin
            frame_d = '0;
            step_d  = step_q + 3'd1;
          end else begin
            frame_d = frame_q + FW'(1);
          end
          data_d    = pack_frame(rom_addr, rom_value);
          en_load_d = (frame_d == FRAME_LAST);
          last_d    = rom_last;
          state_d   = ST_START;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      list_q     <= LIST_INIT;
      step_q     <= '0;
      frame_q    <= '0;
      tmo_q      <= '0;
      pend_q     <= 1'b0;
      pend_int_q <= 4'h0;
      act_int_q  <= 4'h0;
      last_q     <= 1'b0;
      start_q    <= 1'b0;
      en_load_q  <= 1'b0;
      data_q     <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      step_q     <= step_d;
      frame_q    <= frame_d;
      tmo_q      <= tmo_d;
      pend_q     <= pend_d;
      pend_int_q <= pend_int_d;
      act_int_q  <= act_int_d;
      last_q     <= last_d;
      start_q    <= start_d;
      en_load_q  <= en_load_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign o_start   = start_q;
  assign o_en_load = en_load_q;
  assign o_data    = data_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_error   = error_q;

endmodule

// File: tb/tb_max7219_cfg_sequencer.sv
// Directed bench for max7219_cfg_sequencer with a behavioural max7219_if done responder.
// Table-driven sequences plus hand-written pending, timeout and reset cases.
module tb_max7219_cfg_sequencer;

  localparam int NB  = 2;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_init = 1'b0;
  logic        i_upd_int = 1'b0;
  logic [3:0]  i_intensity = 4'h0;
  logic        i_if_done = 1'b0;
  logic        o_start, o_en_load, o_busy, o_done, o_error;
  logic [15:0] o_data;

  always #5 clk = ~clk;

  max7219_cfg_sequencer #(
    .G_NB_MATRIX    (NB),
    .G_DECODE_MODE  (8'h00),
    .G_INTENSITY    (8'h08),
    .G_SCAN_LIMIT   (8'h07),
    .G_DONE_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_init      (i_init),
    .i_upd_int   (i_upd_int),
    .i_intensity (i_intensity),
    .o_start     (o_start),
    .o_en_load   (o_en_load),
    .o_data      (o_data),
    .i_if_done   (i_if_done),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, actual, expected);
  endtask

  // Frame log and handshake responder (answers each o_start with done 4 cycles later).
  logic [15:0] f_data[$];
  bit          f_load[$];
  int          f_cyc[$];
  int          d_cyc[$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          err_cyc = 0;
  bit          busy_at_err = 1'b0;
  bit          block_done = 1'b0;
  int          resp_cnt = 0;

  initial begin : mon_resp
    forever begin
      @(negedge clk);
      if (o_start) begin
        f_data.push_back(o_data);
        f_load.push_back(o_en_load);
        f_cyc.push_back(cyc);
      end
      if (o_done) done_cnt++;
      if (o_error) begin
        err_cnt++;
        err_cyc = cyc;
        busy_at_err = o_busy;
      end
      if (rst) begin
        resp_cnt = 0;
        i_if_done = 1'b0;
      end else if (i_if_done) begin
        i_if_done = 1'b0;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          i_if_done = 1'b1;
          d_cyc.push_back(cyc);
        end
      end else if (o_start && !block_done) begin
        resp_cnt = 4;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    bit         do_init;
    bit         do_upd;
    logic [3:0] inten;
  } vec_t;

  logic [15:0] init_seq[10];
  vec_t        vecs[5];
  int          pulse_cyc;

  task automatic pulse(input bit ini, input bit upd, input logic [3:0] inten);
    @(negedge clk);
    i_init      = ini;
    i_upd_int   = upd;
    i_intensity = inten;
    pulse_cyc   = cyc;
    @(negedge clk);
    i_init    = 1'b0;
    i_upd_int = 1'b0;
  endtask

  task automatic wait_dones(input string name, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    check({name, "_done_seen"}, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_frames(input string name, input int target, input int budget);
    for (int i = 0; i < budget && f_data.size() < target; i++) @(negedge clk);
    check({name, "_frames_seen"}, 32'(f_data.size() >= target), 32'd1);
  endtask

  initial begin : main
    logic [15:0] exp_q[$];
    int base_f, base_d, base_e, base_dc, n_dones;

    init_seq = '{16'h0F00, 16'h0F00, 16'h0900, 16'h0900, 16'h0A08,
                 16'h0A08, 16'h0B07, 16'h0B07, 16'h0C01, 16'h0C01};
    vecs[0] = '{"init",  1'b1, 1'b0, 4'h0};
    vecs[1] = '{"upd_c", 1'b0, 1'b1, 4'hC};
    vecs[2] = '{"upd_0", 1'b0, 1'b1, 4'h0};
    vecs[3] = '{"upd_f", 1'b0, 1'b1, 4'hF};
    vecs[4] = '{"tie_7", 1'b1, 1'b1, 4'h7};

    repeat (3) @(negedge clk);
    check("rst_start",   32'(o_start),   32'd0);
    check("rst_en_load", 32'(o_en_load), 32'd0);
    check("rst_data",    32'(o_data),    32'h0);
    check("rst_busy",    32'(o_busy),    32'd0);
    check("rst_done",    32'(o_done),    32'd0);
    check("rst_error",   32'(o_error),   32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      exp_q.delete();
      if (vecs[v].do_init) for (int k = 0; k < 10; k++) exp_q.push_back(init_seq[k]);
      if (vecs[v].do_upd)  for (int k = 0; k < NB; k++) exp_q.push_back({8'h0A, 4'h0, vecs[v].inten});
      n_dones = int'(vecs[v].do_init) + int'(vecs[v].do_upd);
      base_f  = f_data.size();
      base_d  = done_cnt;
      base_e  = err_cnt;
      base_dc = d_cyc.size();
      pulse(vecs[v].do_init, vecs[v].do_upd, vecs[v].inten);
      wait_dones(vecs[v].name, base_d + n_dones, 1000);
      repeat (20) @(negedge clk);
      check({vecs[v].name, "_nframes"}, 32'(f_data.size() - base_f), 32'(exp_q.size()));
      for (int j = 0; j < exp_q.size(); j++) begin
        if (base_f + j < f_data.size()) begin
          check($sformatf("%s_data%0d", vecs[v].name, j), 32'(f_data[base_f + j]), 32'(exp_q[j]));
          check($sformatf("%s_load%0d", vecs[v].name, j), 32'(f_load[base_f + j]), 32'(j % NB == NB - 1));
        end
      end
      if (f_data.size() > base_f + 1 && d_cyc.size() > base_dc) begin
        check({vecs[v].name, "_start_latency"}, 32'(f_cyc[base_f] - pulse_cyc), 32'd3);
        check({vecs[v].name, "_done_to_start"}, 32'(f_cyc[base_f + 1] - d_cyc[base_dc]), 32'd3);
      end
      check({vecs[v].name, "_ndone"}, 32'(done_cnt - base_d), 32'(n_dones));
      check({vecs[v].name, "_nerr"},  32'(err_cnt - base_e), 32'd0);
      check({vecs[v].name, "_busy_after"}, 32'(o_busy), 32'd0);
    end

    // Two updates during init collapse into one pending update with the last value.
    base_f = f_data.size();
    base_d = done_cnt;
    pulse(1'b1, 1'b0, 4'h0);
    wait_frames("pend", base_f + 2, 200);
    pulse(1'b0, 1'b1, 4'h5);
    repeat (3) @(negedge clk);
    pulse(1'b0, 1'b1, 4'h3);
    wait_dones("pend", base_d + 2, 1000);
    repeat (60) @(negedge clk);
    check("pend_nframes", 32'(f_data.size() - base_f), 32'd12);
    check("pend_ndone",   32'(done_cnt - base_d), 32'd2);
    if (f_data.size() >= base_f + 12) begin
      check("pend_init_last", 32'(f_data[base_f + 9]),  32'h0C01);
      check("pend_upd0",      32'(f_data[base_f + 10]), 32'h0A03);
      check("pend_upd1",      32'(f_data[base_f + 11]), 32'h0A03);
      check("pend_upd1_load", 32'(f_load[base_f + 11]), 32'd1);
    end

    // Done never arrives: watchdog error, then a fresh init must still run.
    block_done = 1'b1;
    base_f = f_data.size();
    base_d = done_cnt;
    base_e = err_cnt;
    pulse(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 300 && err_cnt == base_e; i++) @(negedge clk);
    check("tmo_error_seen", 32'(err_cnt - base_e), 32'd1);
    if (f_data.size() > base_f) check("tmo_latency", 32'(err_cyc - f_cyc[base_f]), 32'd64);
    check("tmo_busy_at_err", 32'(busy_at_err), 32'd0);
    repeat (10) @(negedge clk);
    check("tmo_error_pulse", 32'(o_error), 32'd0);
    check("tmo_nframes", 32'(f_data.size() - base_f), 32'd1);
    check("tmo_ndone",   32'(done_cnt - base_d), 32'd0);
    block_done = 1'b0;
    base_f = f_data.size();
    base_d = done_cnt;
    pulse(1'b1, 1'b0, 4'h0);
    wait_dones("tmo_retry", base_d + 1, 1000);
    check("tmo_retry_nframes", 32'(f_data.size() - base_f), 32'd10);
    if (f_data.size() > base_f) check("tmo_retry_first", 32'(f_data[base_f]), 32'h0F00);

    // Reset during the third frame aborts with no done.
    repeat (5) @(negedge clk);
    base_f = f_data.size();
    base_d = done_cnt;
    pulse(1'b1, 1'b0, 4'h0);
    wait_frames("rstmid", base_f + 3, 200);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_start",   32'(o_start),   32'd0);
    check("rstmid_en_load", 32'(o_en_load), 32'd0);
    check("rstmid_data",    32'(o_data),    32'h0);
    check("rstmid_busy",    32'(o_busy),    32'd0);
    check("rstmid_done",    32'(o_done),    32'd0);
    check("rstmid_error",   32'(o_error),   32'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rstmid_ndone",   32'(done_cnt - base_d), 32'd0);
    check("rstmid_nframes", 32'(f_data.size() - base_f), 32'd3);
    base_f = f_data.size();
    base_d = done_cnt;
    pulse(1'b1, 1'b0, 4'h0);
    wait_dones("rstmid_restart", base_d + 1, 1000);
    check("rstmid_restart_nframes", 32'(f_data.size() - base_f), 32'd10);
    if (f_data.size() > base_f) check("rstmid_restart_first", 32'(f_data[base_f]), 32'h0F00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
